// File: rtl/gauss_pkg.sv
// gauss_pkg: shared constants, FSM state type and slot arithmetic for the Gaussian window buffer
package gauss_pkg;
  localparam int BIT_WIDTH = 8;
  localparam int WIN_ROWS = 5;
  localparam int WIN_COLS = 14;
  localparam int ROW_STEP = 3;
  localparam int COL_STEP = 12;
  typedef enum logic {FILL, EMIT} state_t;
  function automatic logic [2:0] slot_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction
endpackage

// File: rtl/gauss_win_rowbuf.sv
// gauss_win_rowbuf: one image-row slot; column-addressed write, 14-pixel slice read at rcol
// ports: clk; we/wcol/wdata write one pixel; rcol selects slice start; rdata = pixels rcol..rcol+13, first in MSBs
module gauss_win_rowbuf #(
  parameter int BIT_WIDTH = gauss_pkg::BIT_WIDTH,
  parameter int IMG_W = 38,
  localparam int CW = $clog2(IMG_W)
) (
  input  logic                                     clk,
  input  logic                                     we,
  input  logic [CW-1:0]                            wcol,
  input  logic [BIT_WIDTH-1:0]                     wdata,
  input  logic [CW-1:0]                            rcol,
  output logic [gauss_pkg::WIN_COLS*BIT_WIDTH-1:0] rdata
);
  import gauss_pkg::*;
  logic [BIT_WIDTH-1:0] mem [IMG_W];
  always_ff @(posedge clk)
    if (we) mem[wcol] <= wdata;
  always_comb begin
    rdata = '0;
    for (int c = 0; c < WIN_COLS; c++)
      rdata[WIN_COLS*BIT_WIDTH-1-BIT_WIDTH*c -: BIT_WIDTH] = mem[rcol + CW'(c)];
  end
endmodule

// File: rtl/gauss_window_buf.sv
// gauss_window_buf: raster pixels in, 5x14 windows out (row step 3, column step 12)
// ports: clk, rst_n (sync, active-low); pix_in/in_valid/in_ready input stream;
//        pix_out/out_valid/out_ready window stream (r0c0 in MSBs); frame_done pulses on last window accept
module gauss_window_buf #(
  parameter int BIT_WIDTH = gauss_pkg::BIT_WIDTH,
  parameter int IMG_W = 38,
  parameter int IMG_H = 17
) (
  input  logic                                                         clk,
  input  logic                                                         rst_n,
  input  logic [BIT_WIDTH-1:0]                                         pix_in,
  input  logic                                                         in_valid,
  output logic                                                         in_ready,
  output logic [gauss_pkg::WIN_ROWS*gauss_pkg::WIN_COLS*BIT_WIDTH-1:0] pix_out,
  output logic                                                         out_valid,
  input  logic                                                         out_ready,
  output logic                                                         frame_done
);
  import gauss_pkg::*;
  localparam int CW = $clog2(IMG_W);
  localparam int NW = (IMG_W - 2) / COL_STEP;
  localparam int NB = (IMG_H - 2) / ROW_STEP;
  localparam int BBW = $clog2(NB + 1);
  localparam int RW = WIN_COLS * BIT_WIDTH;
  localparam int OW = WIN_ROWS * RW;
  state_t state, state_nx;
  logic [CW-1:0] col_q, wcol_q, rcol;
  logic [2:0] row_q, base_q, need, fill_slot;
  logic [BBW-1:0] band_q;
  logic [OW-1:0] pix_q, pix_d;
  logic [RW-1:0] rd [WIN_ROWS];
  logic first_band, in_fire, out_fire, last_px, last_win, last_band, load;
  assign in_ready = state == FILL;
  assign out_valid = state == EMIT;
  assign pix_out = pix_q;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign first_band = band_q == '0;
  assign need = first_band ? 3'd5 : 3'd3;
  // later bands keep window rows 0-1 in place and refill the slots behind them
  assign fill_slot = slot_add(base_q, slot_add(row_q, first_band ? 3'd0 : 3'd2));
  assign last_px = col_q == CW'(IMG_W - 1) && row_q == need - 3'd1;
  assign last_win = wcol_q == CW'(COL_STEP * (NW - 1));
  assign last_band = band_q == BBW'(NB - 1);
  assign frame_done = out_fire && last_win && last_band;
  // window 0 never touches the band's final pixel, so it can be captured on that pixel's accept
  assign rcol = state == EMIT ? wcol_q + CW'(COL_STEP) : '0;
  assign load = (in_fire && last_px) || (out_fire && !last_win);
  for (genvar i = 0; i < WIN_ROWS; i++) begin : g_row
    gauss_win_rowbuf #(.BIT_WIDTH(BIT_WIDTH), .IMG_W(IMG_W)) u_row (
      .clk(clk),
      .we(in_fire && fill_slot == 3'(i)),
      .wcol(col_q),
      .wdata(pix_in),
      .rcol(rcol),
      .rdata(rd[i])
    );
  end
  always_comb begin
    pix_d = '0;
    for (int r = 0; r < WIN_ROWS; r++)
      pix_d[OW-1-RW*r -: RW] = rd[slot_add(base_q, 3'(r))];
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == FILL && in_fire && last_px) ? EMIT : state_nx;
    state_nx = (state == EMIT && out_fire && last_win) ? FILL : state_nx;
  end
  always_ff @(posedge clk)
    state <= !rst_n ? FILL : state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      base_q <= '0;
      band_q <= '0;
      wcol_q <= '0;
      pix_q <= '0;
    end else begin
      if (in_fire) begin
        col_q <= col_q == CW'(IMG_W - 1) ? '0 : col_q + CW'(1);
        if (col_q == CW'(IMG_W - 1)) row_q <= last_px ? '0 : row_q + 3'd1;
      end
      if (load) pix_q <= pix_d;
      if (out_fire) wcol_q <= last_win ? '0 : wcol_q + CW'(COL_STEP);
      if (out_fire && last_win) begin
        base_q <= slot_add(base_q, 3'(ROW_STEP));
        band_q <= last_band ? '0 : band_q + BBW'(1);
      end
    end
  end
endmodule

// File: tb/tb_gauss_window_buf.sv
// tb_gauss_window_buf: scoreboard bench for gauss_window_buf against an image-array window model
module tb_gauss_window_buf;
  localparam int BW = 8;
  localparam int W = 38;
  localparam int H = 17;
  localparam int OW = 70 * BW;
  localparam int NW = 3;
  localparam int NB = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [BW-1:0] pix_in = '0;
  logic in_ready, out_valid, frame_done;
  logic [OW-1:0] pix_out;
  typedef struct {
    logic [OW-1:0] win;
    bit last;
    bit pat;
    int idx;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] img [H][W];
  int checks = 0;
  int failures = 0;
  int fd_count = 0;
  bit stall_req = 0;
  bit rnd_ready = 0;
  bit prev_hold = 0;
  logic [OW-1:0] prev_pix;

  gauss_window_buf #(.BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_in(pix_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pix_out(pix_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = stall_req ? 1'b0 : rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] px(input logic [OW-1:0] w, input int r, input int c);
    return w[OW-1-BW*(14*r+c) -: BW];
  endfunction

  // window of band b, position k: image rows 3b..3b+4, columns 12k..12k+13
  function automatic logic [OW-1:0] exp_win(input int b, input int k);
    logic [OW-1:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 14; c++)
        w[OW-1-BW*(14*r+c) -: BW] = img[3*b+r][12*k+c];
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) prev_hold = 0;
    else begin
      check("ready_vs_valid", in_ready, !out_valid);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_pix", pix_out, prev_pix);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_window: got %0h expected none", pix_out);
        end else begin
          mon_e = sb.pop_front();
          check("window", pix_out, mon_e.win);
          check("frame_done", frame_done, mon_e.last);
          if (mon_e.pat && mon_e.idx == 0) begin
            check("w0_r0c0", px(pix_out, 0, 0), 0);
            check("w0_r0c13", px(pix_out, 0, 13), 13);
            check("w0_r1c0", px(pix_out, 1, 0), 38);
            check("w0_r4c13", px(pix_out, 4, 13), 165);
          end
          if (mon_e.pat && mon_e.idx == 1) check("w1_r0c0", px(pix_out, 0, 0), 12);
          if (mon_e.pat && mon_e.idx == 3) check("b1w0_r0c0", px(pix_out, 0, 0), 114);
        end
      end else check("frame_done_idle", frame_done, 0);
      if (frame_done) fd_count++;
      prev_hold = out_valid && !out_ready;
      prev_pix = pix_out;
    end
  end

  task automatic abort(input string name);
    failures++;
    $display("FAIL %s: got timeout expected progress", name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  endtask

  task automatic send_px(input logic [7:0] v, input int gap);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    repeat (gap) begin
      in_valid = 0;
      @(posedge clk);
      #1;
    end
    in_valid = 1;
    pix_in = v;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 3000) abort("input_accept");
    end
  endtask

  task automatic send_frame(input bit pat, input bit gaps);
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = pat ? 8'((r * W + c) % 256) : 8'($urandom_range(0, 255));
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < NW; k++) begin
        e.win = exp_win(b, k);
        e.last = (b == NB - 1) && (k == NW - 1);
        e.pat = pat;
        e.idx = b * NW + k;
        sb.push_back(e);
      end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_px(img[r][c], gaps ? int'($urandom_range(0, 3)) : 0);
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1;
    send_frame(1, 0);
    fork
      send_frame(1, 0);
      begin
        int n;
        logic [OW-1:0] held;
        @(posedge clk);
        #2 stall_req = 1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(out_valid && !out_ready) && n < 3000);
        check("stall_seen", out_valid && !out_ready, 1);
        held = pix_out;
        repeat (4) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_in_ready", in_ready, 0);
          check("stall_pix", pix_out, held);
        end
        stall_req = 0;
      end
    join
    drain();
    check("frame_done_count_2", fd_count, 2);
    rnd_ready = 1;
    send_frame(0, 1);
    drain();
    rnd_ready = 0;
    for (int i = 0; i < 100; i++) send_px(8'(i), 0);
    in_valid = 0;
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    sb.delete();
    send_frame(1, 1);
    drain();
    check("frame_done_count_4", fd_count, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gauss_window_buf.md
GAUSS_WINDOW_BUF -- requirements
Module: gauss_window_buf

Interface
REQ-001 The block SHALL take parameter BIT_WIDTH, default 8, as the pixel width in bits.
REQ-002 The block SHALL take parameter IMG_W, default 38, as the image width in pixels; legal values are 12n+2 with n>=1.
REQ-003 The block SHALL take parameter IMG_H, default 17, as the image height in pixels; legal values are 3m+2 with m>=1.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 pix_in  input  BIT_WIDTH  raster-order input pixel.
REQ-007 in_valid  input  1  pix_in is valid.
REQ-008 in_ready  output  1  block accepts pix_in this cycle.
REQ-009 pix_out  output  70*BIT_WIDTH  5-row x 14-column window.
REQ-010 out_valid  output  1  pix_out is valid.
REQ-011 out_ready  input  1  consumer accepts pix_out.
REQ-012 frame_done  output  1  one-cycle pulse when the last window of a frame is accepted.

Function
REQ-013 An input transfer SHALL occur on in_valid&&in_ready, and an output transfer on out_valid&&out_ready.
REQ-014 Pixel (r,c) of a window SHALL sit at pix_out[70*BW-1-BW*(14r+c) -: BW], with r0c0 in the MSBs and row-major order.
REQ-015 Windows SHALL tile the frame with row step 3 and column step 12: band b, window k covers image rows 3b..3b+4 and columns 12k..12k+13.
REQ-016 Each band SHALL produce (IMG_W-2)/12 windows, and each frame SHALL have (IMG_H-2)/3 bands.
REQ-017 The FSM SHALL have states FILL and EMIT.
REQ-018 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-019 In EMIT, in_ready SHALL be 0.
REQ-020 Band 0 of a frame SHALL require 5 rows in FILL; every later band SHALL require 3 new rows and reuse the last 2 rows of the previous band.
REQ-021 FILL SHALL go to EMIT on the cycle after the last required pixel is accepted.
REQ-022 out_valid SHALL assert in EMIT.
REQ-023 Each window SHALL be presented from registers, and pix_out SHALL stay stable while out_valid&&!out_ready.
REQ-024 After an accepted window that is not the band's last, the next window SHALL present on the following cycle, with no bubble.
REQ-025 After the band's last window is accepted, the FSM SHALL go to FILL; if it was the frame's last band, frame_done SHALL pulse in that same cycle and the band counter SHALL wrap to 0.
REQ-026 Row storage SHALL be 5 rotating row slots; the base pointer SHALL advance by 3 mod 5 per band, so no row data is copied.
REQ-027 Column and row counters SHALL wrap at IMG_W-1 and at the number of required rows; there is no overflow condition.
REQ-028 in_valid while in EMIT SHALL be ignored, with no data loss, because in_ready=0.
REQ-029 Data SHALL pass through unmodified, with no arithmetic.

Reset
REQ-030 While rst_n=0 at a clock edge, the FSM SHALL go to FILL and all counters and the base pointer SHALL be 0.
REQ-031 The reset values of the outputs SHALL be: out_valid=0, frame_done=0, pix_out=0, in_ready=1 on the cycle after reset.
REQ-032 Reset asserted mid-FILL or mid-EMIT SHALL discard the partial band and frame; the next accepted pixel is image (0,0).
REQ-033 Row-slot contents need not be reset.

Structure
REQ-034 The shared package gauss_pkg SHALL hold BIT_WIDTH, WIN_ROWS=5, WIN_COLS=14, ROW_STEP=3, COL_STEP=12 and the FSM state enum.
REQ-035 One sub-module, gauss_win_rowbuf, SHALL implement a single row slot: IMG_W x BIT_WIDTH registers, write port by column index, and a read of a 14-pixel slice at a given column offset; it SHALL be instantiated 5 times.
REQ-036 The top level SHALL contain the FSM, the counters, slot selection and the output register.

Verification
All scenarios use IMG_W=38, IMG_H=17 and pixel value (r*38+c) mod 256, with in_valid held 1 unless stated.
REQ-037 Band 0 stimulus -> first window has r0c0=0, r0c13=13, r1c0=38, r4c13=165; the 2nd window has r0c0=12.
REQ-038 Full frame stimulus -> exactly 15 out transfers; frame_done pulses once, in the cycle of the 15th accept; band 1 window 0 has r0c0=114.
REQ-039 out_ready=0 for 4 cycles during EMIT -> pix_out and out_valid held constant and in_ready=0 throughout; the window is accepted once on release.
REQ-040 Random in_valid gaps of 0-3 cycles -> window contents identical to the gapless run.
REQ-041 rst_n=0 for 1 cycle after 100 accepted pixels, then a new frame -> the first window matches REQ-037.
REQ-042 Back-to-back frames -> the first window of frame 2 equals the first window of frame 1, and frame_done pulses exactly twice.
